// File: rtl/generator_ctrl_pkg.sv
// Shared types and constants for the generator sequencer and its parameter bank.
package generator_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_SETTLE,
    ST_STREAM
  } state_t;

  localparam int N_PARAM      = 45;
  localparam int OFF_W_L2     = 0;
  localparam int OFF_W_L3     = 6;
  localparam int OFF_B_L2     = 33;
  localparam int OFF_B_L3     = 36;
  localparam int OUT_LAST_IDX = 8;
  localparam int PTR_W        = 6;
  localparam int IDX_W        = 4;

endpackage

// File: rtl/gen_param_bank.sv
// 45-word parameter register file for the 2-3-9 generator. Words are stored in
// flat load order and fanned out onto the four flattened parameter buses.
module gen_param_bank
  import generator_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int N_INPUT     = 2,
  parameter int N_NEURON_L2 = 3,
  parameter int N_NEURON_L3 = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  we,
  input  logic [PTR_W-1:0]                      addr,
  input  logic [WIDTH-1:0]                      data,
  output logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]     w_L2,
  output logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] w_L3,
  output logic [N_NEURON_L2*WIDTH-1:0]             b_L2,
  output logic [N_NEURON_L3*WIDTH-1:0]             b_L3
);

  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(N_PARAM - 1);

  logic [WIDTH-1:0] bank [N_PARAM];

  // Single write port; addresses beyond the last word are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PARAM; i++) bank[i] <= '0;
    end else if (we && (addr <= LAST_ADDR)) begin
      bank[addr] <= data;
    end
  end

  for (genvar i = 0; i < N_INPUT*N_NEURON_L2; i++) begin : g_w_l2
    assign w_L2[i*WIDTH +: WIDTH] = bank[OFF_W_L2 + i];
  end

  for (genvar i = 0; i < N_NEURON_L2*N_NEURON_L3; i++) begin : g_w_l3
    assign w_L3[i*WIDTH +: WIDTH] = bank[OFF_W_L3 + i];
  end

  for (genvar i = 0; i < N_NEURON_L2; i++) begin : g_b_l2
    assign b_L2[i*WIDTH +: WIDTH] = bank[OFF_B_L2 + i];
  end

  for (genvar i = 0; i < N_NEURON_L3; i++) begin : g_b_l3
    assign b_L3[i*WIDTH +: WIDTH] = bank[OFF_B_L3 + i];
  end

endmodule

// File: rtl/generator_ctrl.sv
// Sequencer around the combinational 2-3-9 generator MLP: loads the parameter
// bank from a serial config stream, holds one sample on the generator inputs
// for SETTLE cycles, captures the 9 outputs and streams them out.
// Optional build macro GENERATOR_CTRL_BURST_OUT_EN: results leave as a single
// beat on out_bus instead of nine serial beats.
module generator_ctrl
  import generator_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int N_INPUT     = 2,
  parameter int N_NEURON_L2 = 3,
  parameter int N_NEURON_L3 = 9,
  parameter int SETTLE      = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cfg_start,
  input  logic                                     cfg_valid,
  output logic                                     cfg_ready,
  input  logic [WIDTH-1:0]                         cfg_data,
  output logic                                     cfg_loaded,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [WIDTH-1:0]                  in_a1,
  input  logic signed [WIDTH-1:0]                  in_a2,
  output logic signed [WIDTH-1:0]                  gen_a_1,
  output logic signed [WIDTH-1:0]                  gen_a_2,
  output logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]     w_L2,
  output logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] w_L3,
  output logic [N_NEURON_L2*WIDTH-1:0]             b_L2,
  output logic [N_NEURON_L3*WIDTH-1:0]             b_L3,
  input  logic [N_NEURON_L3*WIDTH-1:0]             gen_y,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [WIDTH-1:0]                         out_data,
  output logic [IDX_W-1:0]                         out_idx,
  output logic                                     out_last,
  output logic                                     busy
`ifdef GENERATOR_CTRL_BURST_OUT_EN
  ,
  output logic [N_NEURON_L3*WIDTH-1:0]             out_bus
`endif
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_PARAM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_LAST_IDX);
`ifdef GENERATOR_CTRL_BURST_OUT_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = LAST_IDX;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
`endif

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] res_buf [N_NEURON_L3];
  logic             cfg_hs, in_hs, out_hs, start_ok, capture;

  assign cfg_hs   = cfg_valid && cfg_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign start_ok = cfg_start &&
                    ((state == ST_IDLE) || (state == ST_LOAD) || (state == ST_READY));
  assign capture  = (state == ST_SETTLE) && (cnt == CNT_W'(1));
  assign out_idx  = idx;

  gen_param_bank #(
    .WIDTH       (WIDTH),
    .N_INPUT     (N_INPUT),
    .N_NEURON_L2 (N_NEURON_L2),
    .N_NEURON_L3 (N_NEURON_L3)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_hs),
    .addr  (ptr),
    .data  (cfg_data),
    .w_L2  (w_L2),
    .w_L3  (w_L3),
    .b_L2  (b_L2),
    .b_L3  (b_L3)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; cfg_start has priority over a sample in READY.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cfg_start) state_nxt = ST_LOAD;
      ST_LOAD:   if (cfg_hs && (ptr == LAST_PTR)) state_nxt = ST_READY;
      ST_READY: begin
        if (cfg_start)  state_nxt = ST_LOAD;
        else if (in_hs) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: if (capture) state_nxt = ST_STREAM;
      ST_STREAM: if (out_hs && out_last) state_nxt = ST_READY;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and result outputs decoded from the current state.
  always_comb begin
    cfg_ready = (state == ST_LOAD) && !cfg_start;
    in_ready  = (state == ST_READY) && !cfg_start;
    out_valid = (state == ST_STREAM);
    out_last  = (state == ST_STREAM) && (idx == LAST_IDX);
    busy      = (state == ST_SETTLE) || (state == ST_STREAM);
`ifdef GENERATOR_CTRL_BURST_OUT_EN
    out_data  = res_buf[0];
`else
    out_data  = res_buf[idx];
`endif
  end

`ifdef GENERATOR_CTRL_BURST_OUT_EN
  for (genvar k = 0; k < N_NEURON_L3; k++) begin : g_out_bus
    assign out_bus[k*WIDTH +: WIDTH] = res_buf[k];
  end
`endif

  // Load pointer, sample hold, settle countdown, result capture and out index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      cnt        <= '0;
      idx        <= '0;
      cfg_loaded <= 1'b0;
      gen_a_1    <= '0;
      gen_a_2    <= '0;
      for (int k = 0; k < N_NEURON_L3; k++) res_buf[k] <= '0;
    end else begin
      if (start_ok) begin
        ptr        <= '0;
        cfg_loaded <= 1'b0;
      end else if (cfg_hs) begin
        if (ptr == LAST_PTR) begin
          ptr        <= '0;
          cfg_loaded <= 1'b1;
        end else begin
          ptr <= ptr + PTR_W'(1);
        end
      end
      if (in_hs) begin
        gen_a_1 <= in_a1;
        gen_a_2 <= in_a2;
        cnt     <= CNT_W'(SETTLE);
      end else if (state == ST_SETTLE) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        for (int k = 0; k < N_NEURON_L3; k++) res_buf[k] <= gen_y[k*WIDTH +: WIDTH];
        idx <= FIRST_IDX;
      end else if (out_hs) begin
        idx <= out_last ? '0 : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: doc/generator_ctrl.md
Name: generator_ctrl

Overview:
- Sequencer wrapped around the 2-3-9 generator MLP datapath, which is purely combinational.
- Loads all 45 weight/bias words from a serial config stream into a parameter bank and drives them onto the generator's flat parameter buses.
- Accepts one (a_1, a_2) sample per valid/ready handshake, waits a fixed settle time, captures the 9 outputs, then streams them out one word per handshake.

Parameters:
- WIDTH, 32, word width of activations, weights and biases (signed).
- N_INPUT, 2, generator input count.
- N_NEURON_L2, 3, hidden-layer neuron count.
- N_NEURON_L3, 9, output neuron count.
- SETTLE, 2, cycles (>=1) that the generator inputs are held stable before outputs are captured; sets the multicycle path.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  pulse; clears load pointer and enters LOAD.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  config word accepted when high with cfg_valid.
- cfg_data  in  WIDTH  config word.
- cfg_loaded  out  1  all 45 words loaded since last start/reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted.
- in_a1, in_a2  in  WIDTH each  sample.
- gen_a_1, gen_a_2  out  WIDTH each  to generator.
- w_L2  out  N_INPUT*N_NEURON_L2*WIDTH  to generator.
- w_L3  out  N_NEURON_L2*N_NEURON_L3*WIDTH  to generator; this sizing is decided.
- b_L2  out  N_NEURON_L2*WIDTH  to generator.
- b_L3  out  N_NEURON_L3*WIDTH  to generator.
- gen_y  in  N_NEURON_L3*WIDTH  generator outputs {y_3x3..y_1x1}; word k is y index k.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  result word.
- out_idx  out  4  result index 0..8.
- out_last  out  1  high with index 8.
- busy  out  1  state is SETTLE or STREAM.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - state=IDLE, cfg_loaded=0.
  - load pointer, settle counter and out index all 0.
  - all outputs 0, including the parameter bank and gen_a_*.
- States: IDLE, LOAD, READY, SETTLE, STREAM.
- IDLE:
  - cfg_ready=0, in_ready=0.
  - cfg_start -> LOAD.
- LOAD:
  - cfg_ready=1.
  - Each cfg handshake writes cfg_data to bank[ptr], then ptr++.
  - Flat order: w_L2 words 0-5, w_L3 words 6-32, b_L2 words 33-35, b_L3 words 36-44.
  - Within a bus, word i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
  - Handshake on ptr=44: cfg_loaded=1 next cycle, go to READY.
  - cfg_start while in LOAD restarts the load: ptr=0, no write that cycle.
- READY:
  - in_ready=1 and cfg_ready=0.
  - in handshake: register in_a1/in_a2 onto gen_a_*, set settle counter to SETTLE, go to SETTLE.
  - cfg_start while in READY: cfg_loaded=0, go to LOAD. If in_valid is high in the same cycle, cfg_start wins and in_ready is forced low.
- SETTLE:
  - in_ready=0; counter decrements each cycle.
  - In the cycle the counter reads 1, all 9 words of gen_y are captured into the output buffer; next state is STREAM, out_idx=0.
  - With SETTLE=2, the sample handshake occurs at cycle t, capture at t+2, and out_valid rises at t+3.
- STREAM:
  - out_valid=1, out_data=buf[out_idx], out_last=(out_idx==8).
  - Data must hold stable while out_valid && !out_ready.
  - On handshake: out_idx++. On handshake with out_last -> READY, out_valid=0 next cycle.
  - No bubble between words when out_ready is held high.
- cfg_start is ignored in SETTLE and STREAM.
- gen_a_* and the parameter bank are held constant through SETTLE and STREAM.
- No arithmetic in this block; words pass through bit-exact. Width rules: ptr is 6 bits, settle counter is $clog2(SETTLE+1) bits.
- Reset asserted mid-operation aborts the current result; the bank must be reloaded.

Optional Feature:
- Macro: GENERATOR_CTRL_BURST_OUT_EN.
- Defined: adds port out_bus (out, N_NEURON_L3*WIDTH).
  - STREAM presents all 9 words at once with a single out_valid/out_ready handshake.
  - out_last=1 and out_idx=8 during that beat.
  - out_data carries word 0.
  - Result latency is unchanged; the beat count becomes 1.
- Undefined: serial 9-beat stream as described in Behaviour; out_bus does not exist.

Decomposition:
- Package generator_ctrl_pkg holds:
  - state enum (IDLE, LOAD, READY, SETTLE, STREAM);
  - N_PARAM=45;
  - offsets OFF_W_L2=0, OFF_W_L3=6, OFF_B_L2=33, OFF_B_L3=36;
  - OUT_LAST_IDX=8.
- One sub-module: gen_param_bank, a 45 x WIDTH register file with a write port (we, addr, data) and flattened bus outputs w_L2/w_L3/b_L2/b_L3.

Test Plan:
1. Reset, cfg_start, stream words 0x1..0x2D with cfg_valid held high -> cfg_loaded rises after 45 handshakes; w_L2[31:0]=0x1, w_L3[31:0]=0x7, b_L2[31:0]=0x22, b_L3[WIDTH*9-1 -: 32]=0x2D.
2. After load, send a1=0x00010000, a2=0xFFFF0000 with gen_y driven by a reference model and out_ready=1 -> gen_a_* match the inputs at t+1; out_valid at t+3; 9 consecutive beats idx 0..8; out_last only at beat 8.
3. Backpressure: out_ready toggles 1,0,0,1 during STREAM -> out_data and out_idx hold while stalled; no word is lost or duplicated.
4. Throttle cfg_valid every other cycle; issue cfg_start at ptr=20 -> ptr restarts at 0; cfg_loaded is set only after 45 fresh words.
5. Assert rst_n low in STREAM at idx 4 -> all outputs 0 immediately; cfg_loaded=0; in_ready stays 0 until reload completes.
6. In READY, assert in_valid and cfg_start together -> sample not accepted; state LOAD; cfg_loaded=0.
